// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order register writeback queue with two forwarding lookups
module writeback_buffer #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int REG_SIZE      = 32,
    parameter int DEPTH         = 4,
    parameter int PTR_WIDTH     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_addr,
    input  logic [REG_SIZE-1:0]      alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [REG_SIZE-1:0]      mem_data,
    input  logic                     hold,
    output logic                     write_en,
    output logic [ADDRESS_WIDTH-1:0] write_reg_addr,
    output logic [REG_SIZE-1:0]      write_reg_data_in,
    input  logic [ADDRESS_WIDTH-1:0] fwd_a_addr,
    output logic                     fwd_a_hit,
    output logic [REG_SIZE-1:0]      fwd_a_data,
    input  logic [ADDRESS_WIDTH-1:0] fwd_b_addr,
    output logic                     fwd_b_hit,
    output logic [REG_SIZE-1:0]      fwd_b_data,
    output logic [PTR_WIDTH:0]       pending_count
);

    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] entry_addr [DEPTH];
    logic [REG_SIZE-1:0]      entry_data [DEPTH];
    logic [PTR_WIDTH-1:0]     head;
    logic [PTR_WIDTH-1:0]     tail;
    logic [PTR_WIDTH:0]       count;

    logic                     full;
    logic                     not_empty;
    logic                     alu_take;
    logic                     mem_take;
    logic                     enqueue;
    logic                     drain;
    logic [ADDRESS_WIDTH-1:0] enq_addr;
    logic [REG_SIZE-1:0]      enq_data;

    assign full      = (count == FULL_COUNT);
    assign not_empty = (count != '0);

    // ALU has fixed priority; a draining entry does not make room this cycle
    assign alu_ready = !full;
    assign mem_ready = !full && !alu_valid;
    assign alu_take  = alu_valid && alu_ready;
    assign mem_take  = mem_valid && mem_ready;

    always_comb begin
        enq_addr = mem_addr;
        enq_data = mem_data;
        if (alu_take) begin
            enq_addr = alu_addr;
            enq_data = alu_data;
        end
    end

    // r0 requests complete their handshake but are never stored
    assign enqueue = (alu_take || mem_take) && (enq_addr != '0);

    // The write port is suppressed during the reset cycle so nothing stale commits
    assign drain = reset && not_empty && !hold;

    assign write_en          = drain;
    assign write_reg_addr    = not_empty ? entry_addr[head] : '0;
    assign write_reg_data_in = not_empty ? entry_data[head] : '0;
    assign pending_count     = count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enqueue) begin
                entry_addr[tail] <= enq_addr;
                entry_data[tail] <= enq_data;
                tail             <= tail + PTR_ONE;
            end
            if (drain) begin
                head <= head + PTR_ONE;
            end
            if (enqueue && !drain) begin
                count <= count + CNT_ONE;
            end else if (drain && !enqueue) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_WIDTH+1)'(k) < count) begin
                if ((fwd_a_addr != '0) && (entry_addr[head + PTR_WIDTH'(k)] == fwd_a_addr)) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = entry_data[head + PTR_WIDTH'(k)];
                end
                if ((fwd_b_addr != '0) && (entry_addr[head + PTR_WIDTH'(k)] == fwd_b_addr)) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = entry_data[head + PTR_WIDTH'(k)];
                end
            end
        end
    end

endmodule
